mips_cpu_alu_arbiter: RTL
=========================

MIPS_CPU_ALU_ARBITER -- requirements
Module: mips_cpu_alu_arbiter

Interface
REQ-001 SHALL expose: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose: rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL expose per requester k in {0,1}: reqk_valid in 1; reqk_ready out 1; reqk_control in 4 (ALU opcode); reqk_shamt in 5; reqk_a in 32; reqk_b in 32.
REQ-004 SHALL expose per requester k: respk_valid  out  1  one-cycle pulse, result for requester k.
REQ-005 SHALL expose shared response: resp_data out 32; resp_zero out 1; resp_equal out 1; resp_negative out 1.
REQ-006 SHALL expose ALU side: alu_control out 4; alu_shift_amt out 5; alu_a out 32; alu_b out 32; alu_out in 32; alu_zero in 1; alu_equal in 1; alu_negative in 1.

Function
REQ-007 SHALL implement FSM states IDLE, EXEC, RESP; transitions IDLE->EXEC on accept, EXEC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-008 SHALL accept a request only in IDLE: reqk_ready = (state==IDLE) && grant==k && reqk_valid; accept = valid && ready.
REQ-009 SHALL assert at most one reqk_ready per cycle; no ready in EXEC or RESP.
REQ-010 SHALL latch control, shamt, a, b of the granted requester and its ID on accept.
REQ-011 SHALL drive alu_* from latched operands only in EXEC; outside EXEC drive alu_control=4'h0, alu_shift_amt=0, alu_a=0, alu_b=0.
REQ-012 SHALL capture alu_out and the three flags into response registers at the end of EXEC.
REQ-013 SHALL pulse respk_valid for exactly the RESP cycle, k = latched ID; latency accept-edge to respk_valid = 2 cycles; throughput 1 op per 3 cycles.
REQ-014 SHALL hold resp_data and resp_* flags stable from RESP until the next EXEC capture.
REQ-015 SHALL pass the 4-bit opcode through unmodified; undefined opcodes are the ALU's concern.
REQ-016 SHALL tolerate reqk_valid deassertion before acceptance (request withdrawn, no response).
REQ-017 SHALL ignore changes to reqk_* operands after acceptance.
REQ-018 SHALL arbitrate in IDLE only; a lone valid requester is granted regardless of priority.

Reset
REQ-019 SHALL on rst_n=0 at a rising edge: state=IDLE, resp_data=0, flags=0, respk_valid=0, last-grant pointer=1, latched operands=0.
REQ-020 SHALL drop any in-flight operation on reset (EXEC or RESP); no respk_valid is emitted for it after reset release.
REQ-021 SHALL hold all reqk_ready=0 while rst_n=0.

Configuration
REQ-022 SHALL, with macro MIPS_CPU_ALU_ARB_ROUND_ROBIN_EN defined, grant on simultaneous valids the requester not granted last; pointer updates on each accept.
REQ-023 SHALL, without MIPS_CPU_ALU_ARB_ROUND_ROBIN_EN, use fixed priority: requester 0 always wins simultaneous valids; pointer register absent.

Verification
REQ-024 SHALL cover: reset release, req0 ADDU a=5 b=7 -> req0_ready cycle N, resp0_valid cycle N+2, resp_data=12, zero=0, equal=0, negative=0.
REQ-025 SHALL cover: req1 SRA shamt=4 b=32'h80000000 -> resp1_valid, resp_data=32'hF8000000; alu_* zero outside EXEC.
REQ-026 SHALL cover: both valid continuously with RR enabled -> grants 0,1,0,1 on cycles N, N+3, N+6, N+9; RR disabled -> grants 0,0,0,0.
REQ-027 SHALL cover: req0 SUBU a=3 b=3 accepted, rst_n=0 during EXEC -> no resp0_valid, resp_data=0, state IDLE, next request served normally.
REQ-028 SHALL cover: req1 valid raised in EXEC of req0's op, req1 a changed after acceptance -> req1_ready only in next IDLE; req1 result uses operands sampled at acceptance.
REQ-029 SHALL cover: req0 SLT a=-1 b=1 -> resp_data=1, negative=1; resp_data held at 1 for 5 idle cycles after.

Source files
------------

// File: rtl/mips_cpu_alu_arbiter.sv
// ============================================================================
// mips_cpu_alu_arbiter : two-requester arbiter in front of a shared MIPS ALU.
// Optional round-robin arbitration: define MIPS_CPU_ALU_ARB_ROUND_ROBIN_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_cpu_alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_control,
  input  logic [4:0]  req0_shamt,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_control,
  input  logic [4:0]  req1_shamt,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,

  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_data,
  output logic        resp_zero,
  output logic        resp_equal,
  output logic        resp_negative,

  output logic [3:0]  alu_control,
  output logic [4:0]  alu_shift_amt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_equal,
  input  logic        alu_negative
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        id_q, id_d;
  logic [31:0] data_q, data_d;
  logic        zero_q, zero_d;
  logic        equal_q, equal_d;
  logic        neg_q, neg_d;
  logic [1:0]  rvalid_q, rvalid_d;

  logic        grant;
  logic        accept;
  logic        in_idle;
  logic        in_exec;

`ifdef MIPS_CPU_ALU_ARB_ROUND_ROBIN_EN
  logic        last_q, last_d;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else begin
      grant = ~req0_valid;
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = grant;
    end
  end
`else
  always_comb begin
    grant = ~req0_valid;
  end
`endif

  assign in_idle = (state_q == ST_IDLE);
  assign in_exec = (state_q == ST_EXEC);

  // Ready is gated by rst_n so nothing is handshaken while reset is held.
  assign req0_ready = rst_n && in_idle && !grant && req0_valid;
  assign req1_ready = rst_n && in_idle &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    shamt_d  = shamt_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    data_d   = data_q;
    zero_d   = zero_q;
    equal_d  = equal_q;
    neg_d    = neg_q;
    rvalid_d = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXEC;
          id_d    = grant;
          if (grant) begin
            ctrl_d  = req1_control;
            shamt_d = req1_shamt;
            a_d     = req1_a;
            b_d     = req1_b;
          end else begin
            ctrl_d  = req0_control;
            shamt_d = req0_shamt;
            a_d     = req0_a;
            b_d     = req0_b;
          end
        end
      end
      ST_EXEC: begin
        state_d  = ST_RESP;
        data_d   = alu_out;
        zero_d   = alu_zero;
        equal_d  = alu_equal;
        neg_d    = alu_negative;
        rvalid_d = id_q ? 2'b10 : 2'b01;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= 4'h0;
      shamt_q  <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      id_q     <= 1'b0;
      data_q   <= 32'd0;
      zero_q   <= 1'b0;
      equal_q  <= 1'b0;
      neg_q    <= 1'b0;
      rvalid_q <= 2'b00;
`ifdef MIPS_CPU_ALU_ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      shamt_q  <= shamt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      equal_q  <= equal_d;
      neg_q    <= neg_d;
      rvalid_q <= rvalid_d;
`ifdef MIPS_CPU_ALU_ARB_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

  // The ALU only sees operands during EXEC; it is fed zeros otherwise.
  assign alu_control   = in_exec ? ctrl_q  : 4'h0;
  assign alu_shift_amt = in_exec ? shamt_q : 5'd0;
  assign alu_a         = in_exec ? a_q     : 32'd0;
  assign alu_b         = in_exec ? b_q     : 32'd0;

  assign resp0_valid   = rvalid_q[0];
  assign resp1_valid   = rvalid_q[1];
  assign resp_data     = data_q;
  assign resp_zero     = zero_q;
  assign resp_equal    = equal_q;
  assign resp_negative = neg_q;

endmodule

`default_nettype wire
